// File: rtl/aes_subbytes_seq.sv
// aes_subbytes_seq: sequential SubBytes engine feeding LANES external sboxes per cycle; define AES_SUBBYTES_SHIFTROWS_EN to add ShiftRows wiring on out_data
module aes_subbytes_seq #(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [8*LANES-1:0] sb_sel,
  input  logic [8*LANES-1:0] sb_out,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] STEP = 5'(LANES);
  localparam logic [4:0] LAST = 5'(16 - LANES);
  state_t     state;
  logic [4:0] idx;
  logic [7:0] src [16];
  logic [7:0] res [16];
  // control FSM, byte buffers and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        src[i] <= '0;
        res[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (in_valid) begin
        for (int i = 0; i < 16; i++) src[i] <= in_data[127-8*i -: 8];
        idx      <= '0;
        state    <= RUN;
        in_ready <= 1'b0;
        busy     <= 1'b1;
      end
    end else if (state == RUN) begin
      for (int k = 0; k < LANES; k++) res[idx[3:0] + 4'(k)] <= sb_out[8*k +: 8];
      idx <= idx + STEP;
      if (idx == LAST) begin
        state     <= DONE;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end
  end
  // current window of source bytes to the sbox lanes, zero outside RUN
  always_comb begin
    sb_sel = '0;
    for (int k = 0; k < LANES; k++) sb_sel[8*k +: 8] = (state == RUN) ? src[idx[3:0] + 4'(k)] : 8'h00;
  end
  // result bytes back to FIPS-197 order, optionally ShiftRows-permuted
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 16; i++)
`ifdef AES_SUBBYTES_SHIFTROWS_EN
      out_data[127-8*i -: 8] = res[4'((i % 4) + 4 * (((i / 4) + (i % 4)) % 4))];
`else
      out_data[127-8*i -: 8] = res[4'(i)];
`endif
  end
endmodule
